// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
//   I2C target (responder). SCL and SDA are oversampled on clk_i, START and
//   STOP are detected from the synchronised lines, and only frames that carry
//   this target's 7-bit address are acknowledged. Write bytes are presented
//   on rx_data_o with a one-cycle rx_valid_o strobe. Read bytes are taken
//   from tx_data_i, and each load is marked by a one-cycle tx_ack_o strobe.
//   SDA is driven open-drain only (sda_oe_o = 1 pulls the pad low). SCL is
//   never stretched.
//
// Parameters
//   TGT_ADDR     7-bit bus address this target answers to
//   SYNC_STAGES  flops per input synchroniser (>= 2)
//
// Ports
//   clk_i       system clock, at least 8x the SCL frequency
//   rst_n_i     asynchronous active-low reset
//   scl_i       bus SCL (asynchronous)
//   sda_i       bus SDA pad input (asynchronous)
//   sda_oe_o    1 = pull SDA low, 0 = release
//   tx_data_i   byte returned in the next read data phase
//   tx_ack_o    1-cycle pulse: tx_data_i was loaded
//   rx_data_o   last byte received in a write transfer
//   rx_valid_o  1-cycle pulse: rx_data_o updated
//   busy_o      high from the address ACK until the next START or STOP
// ---------------------------------------------------------------------------
module i2c_target #(
    parameter logic [6:0] TGT_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_ack_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_d_reg;
    logic                   sda_d_reg;

    // The synchronisers reset to 1 so that an idle bus (both lines high)
    // produces no spurious edge when reset is released.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_d_reg    <= 1'b1;
            sda_d_reg    <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
            scl_d_reg    <= scl_sync_reg[SYNC_STAGES-1];
            sda_d_reg    <= sda_sync_reg[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s    = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s    = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d_reg;
    assign scl_fall = ~scl_s & scl_d_reg;

    // SCL must be high both before and after the SDA transition. While this
    // target pulls SDA low, a transition on SDA is the target's own doing
    // and must not be taken as a bus condition.
    assign start_det = ~sda_oe_o & scl_s & scl_d_reg & sda_d_reg & ~sda_s;
    assign stop_det  = ~sda_oe_o & scl_s & scl_d_reg & ~sda_d_reg & sda_s;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t     state_reg,    state_next;
    logic [2:0] bit_cnt_reg,  bit_cnt_next;
    logic [6:0] shift_reg,    shift_next;     // bits received so far
    logic [6:0] tx_shift_reg, tx_shift_next;  // read bits not yet driven
    logic       rw_reg,       rw_next;
    logic       got_ack_reg,  got_ack_next;   // master ACKed the read byte
    logic       sda_oe_reg,   sda_oe_next;
    logic       busy_reg,     busy_next;
    logic [7:0] rx_data_reg,  rx_data_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       tx_ack_reg,   tx_ack_next;

    logic [7:0] byte_in;
    assign byte_in = {shift_reg, sda_s};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 7'd0;
            tx_shift_reg <= 7'd0;
            rw_reg       <= 1'b0;
            got_ack_reg  <= 1'b0;
            sda_oe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            rx_data_reg  <= 8'h00;
            rx_valid_reg <= 1'b0;
            tx_ack_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            tx_shift_reg <= tx_shift_next;
            rw_reg       <= rw_next;
            got_ack_reg  <= got_ack_next;
            sda_oe_reg   <= sda_oe_next;
            busy_reg     <= busy_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            tx_ack_reg   <= tx_ack_next;
        end
    end

    // SCL edges are seen one cycle late, so every change of sda_oe lands
    // in the cycle after the synchronised SCL fall.
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        tx_shift_next = tx_shift_reg;
        rw_next       = rw_reg;
        got_ack_next  = got_ack_reg;
        sda_oe_next   = sda_oe_reg;
        busy_next     = busy_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        tx_ack_next   = 1'b0;

        if (start_det) begin
            // A repeated START always restarts address decoding.
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
            bit_cnt_next = 3'd0;
            got_ack_next = 1'b0;
            state_next   = ADDR;
        end else if (stop_det) begin
            // Any partial byte is dropped without a valid strobe.
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
            bit_cnt_next = 3'd0;
            got_ack_next = 1'b0;
            state_next   = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    sda_oe_next = 1'b0;
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_next   = byte_in[6:0];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            rw_next = sda_s;
                            // Address 0 (general call) never matches.
                            if ((byte_in[7:1] == TGT_ADDR) && (byte_in[7:1] != 7'd0))
                                state_next = ADDR_ACK;
                            else
                                state_next = IGNORE;
                        end
                    end
                end

                // sda_oe itself tells the two falls apart: the first fall
                // starts the ACK bit and the second one ends it.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                            busy_next   = 1'b1;
                        end else if (rw_reg) begin
                            tx_shift_next = tx_data_i[6:0];
                            sda_oe_next   = ~tx_data_i[7];
                            tx_ack_next   = 1'b1;
                            bit_cnt_next  = 3'd0;
                            state_next    = RD_DATA;
                        end else begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = 3'd0;
                            state_next   = WR_DATA;
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shift_next   = byte_in[6:0];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            rx_data_next  = byte_in;
                            rx_valid_next = 1'b1;
                            state_next    = WR_ACK;
                        end
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                        end else begin
                            sda_oe_next = 1'b0;
                            state_next  = WR_DATA;
                        end
                    end
                end

                // bit_cnt counts the bits already driven. Bit 7 went out
                // when the byte was loaded, so bit_cnt = 7 means bit 0's
                // period has just ended.
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 3'd7) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = 3'd0;
                            got_ack_next = 1'b0;
                            state_next   = RD_ACK;
                        end else begin
                            sda_oe_next   = ~tx_shift_reg[6];
                            tx_shift_next = {tx_shift_reg[5:0], 1'b0};
                            bit_cnt_next  = bit_cnt_reg + 3'd1;
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s)
                            state_next = IGNORE;
                        else
                            got_ack_next = 1'b1;
                    end else if (scl_fall && got_ack_reg) begin
                        tx_shift_next = tx_data_i[6:0];
                        sda_oe_next   = ~tx_data_i[7];
                        tx_ack_next   = 1'b1;
                        bit_cnt_next  = 3'd0;
                        got_ack_next  = 1'b0;
                        state_next    = RD_DATA;
                    end
                end

                IGNORE: begin
                    sda_oe_next = 1'b0;
                end

                default: begin
                    sda_oe_next = 1'b0;
                    state_next  = IDLE;
                end
            endcase
        end
    end

    assign sda_oe_o   = sda_oe_reg;
    assign busy_o     = busy_reg;
    assign rx_data_o  = rx_data_reg;
    assign rx_valid_o = rx_valid_reg;
    assign tx_ack_o   = tx_ack_reg;

endmodule

// File: tb/tb_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_target
//   Directed bench for i2c_target. The bench models a bit-banged bus master
//   and a wired-AND SDA line. Single-byte transactions are listed in a
//   vector table. Multi-byte reads, repeated START, aborts and reset in the
//   middle of a transfer are written out as explicit sequences.
// ---------------------------------------------------------------------------
module tb_i2c_target;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       scl = 1'b1;
    logic       master_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe_o;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_ack_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       busy_o;

    assign sda_bus = master_sda & ~sda_oe_o;

    i2c_target #(
        .TGT_ADDR    (7'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .scl_i      (scl),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe_o),
        .tx_data_i  (tx_data_i),
        .tx_ack_o   (tx_ack_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Strobe and drive monitors. They only count up; the tests work with
    // differences between counter snapshots.
    int rx_cnt = 0;
    int tx_cnt = 0;
    int oe_cnt = 0;
    always @(negedge clk_i) begin
        if (rx_valid_o) rx_cnt <= rx_cnt + 1;
        if (tx_ack_o)   tx_cnt <= tx_cnt + 1;
        if (sda_oe_o)   oe_cnt <= oe_cnt + 1;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_vec = n_vec + 1;
        if (act !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp_v);
        end
    endtask

    localparam int Q = 8;   // clk cycles per SCL quarter period

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk_i);
    endtask

    // One SCL pulse: set SDA during the low phase, sample the bus mid-high.
    task automatic clock_bit(input logic b, output logic s);
        repeat (2) @(negedge clk_i);
        master_sda = b;
        wait_q(2);
        scl = 1'b1;
        wait_q(1);
        s = sda_bus;
        wait_q(1);
        scl = 1'b0;
    endtask

    task automatic bus_start();
        repeat (2) @(negedge clk_i);
        master_sda = 1'b1;
        wait_q(2);
        scl = 1'b1;
        wait_q(2);
        master_sda = 1'b0;
        wait_q(1);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        repeat (2) @(negedge clk_i);
        master_sda = 1'b0;
        wait_q(2);
        scl = 1'b1;
        wait_q(1);
        master_sda = 1'b1;
        wait_q(2);
    endtask

    // Returns the ACK bit seen on the bus (0 = ACK).
    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, ack);
    endtask

    // mack = 0 sends ACK after the byte, 1 sends NACK.
    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(mack, s);
    endtask

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;      // write byte, or tx_data_i for a read
        logic       mack;      // master ACK bit after a read byte
        logic       exp_aack;  // bus level at the address ACK slot
        logic [7:0] exp_byte;  // write: data ACK slot level; read: byte seen
        logic [7:0] exp_rx;
        logic [7:0] exp_rxv;
        logic [7:0] exp_txa;
        logic       exp_busy;  // busy_o just before STOP
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        vec_t       v;
        logic       a;
        logic       b;
        logic [7:0] got;
        logic       busy_mid;
        int         rx0, tx0, oe0;

        vecs[0] = '{1'b0, 8'h84, 8'hA5, 1'b1, 1'b0, 8'h00, 8'hA5, 8'd1, 8'd0, 1'b1};
        vecs[1] = '{1'b1, 8'h85, 8'h3C, 1'b1, 1'b0, 8'h3C, 8'hA5, 8'd0, 8'd1, 1'b1};
        vecs[2] = '{1'b0, 8'h90, 8'h55, 1'b1, 1'b1, 8'h01, 8'hA5, 8'd0, 8'd0, 1'b0};
        vecs[3] = '{1'b0, 8'h84, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'd1, 8'd0, 1'b1};
        vecs[4] = '{1'b1, 8'h85, 8'h81, 1'b1, 1'b0, 8'h81, 8'h00, 8'd0, 8'd1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 8'h12, 1'b1, 1'b1, 8'h01, 8'h00, 8'd0, 8'd0, 1'b0};
        vecs[6] = '{1'b1, 8'h91, 8'h5A, 1'b1, 1'b1, 8'hFF, 8'h00, 8'd0, 8'd0, 1'b0};
        vecs[7] = '{1'b0, 8'h84, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h5A, 8'd1, 8'd0, 1'b1};
        vecs[8] = '{1'b0, 8'h86, 8'h77, 1'b1, 1'b1, 8'h01, 8'h5A, 8'd0, 8'd0, 1'b0};

        // ---------------- reset state ----------------
        repeat (5) @(negedge clk_i);
        check("rst_sda_oe",   {7'd0, sda_oe_o},   8'h00);
        check("rst_tx_ack",   {7'd0, tx_ack_o},   8'h00);
        check("rst_rx_data",  rx_data_o,          8'h00);
        check("rst_rx_valid", {7'd0, rx_valid_o}, 8'h00);
        check("rst_busy",     {7'd0, busy_o},     8'h00);
        rst_n_i = 1'b1;
        wait_q(2);

        // ---------------- table of single-byte transactions ----------------
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            tx_data_i = v.data;
            rx0 = rx_cnt; tx0 = tx_cnt; oe0 = oe_cnt;
            bus_start();
            write_byte(v.addr, a);
            if (v.rd) begin
                read_byte(v.mack, got);
            end else begin
                write_byte(v.data, b);
                got = {7'd0, b};
            end
            busy_mid = busy_o;
            bus_stop();
            $display("txn %0d: %s addr=%02h data=%02h aack=%0b byte=%02h rx=%02h busy=%0b",
                     i, v.rd ? "read " : "write", v.addr, v.data, a, got, rx_data_o, busy_mid);
            check("addr_ack",  {7'd0, a},          {7'd0, v.exp_aack});
            check("data_byte", got,                v.exp_byte);
            check("rx_data",   rx_data_o,          v.exp_rx);
            check("rx_valid#", 8'(rx_cnt - rx0),   v.exp_rxv);
            check("tx_ack#",   8'(tx_cnt - tx0),   v.exp_txa);
            check("busy_mid",  {7'd0, busy_mid},   {7'd0, v.exp_busy});
            check("busy_stop", {7'd0, busy_o},     8'h00);
            check("oe_stop",   {7'd0, sda_oe_o},   8'h00);
            check("oe_used",   {7'd0, oe_cnt != oe0}, {7'd0, ~v.exp_aack});
        end

        // ---------------- multi-byte read: ACK then NACK ----------------
        tx_data_i = 8'h11;
        tx0 = tx_cnt;
        bus_start();
        write_byte(8'h85, a);
        read_byte(1'b0, got);
        tx_data_i = 8'h22;
        check("mr_aack",  {7'd0, a}, 8'h00);
        check("mr_byte0", got, 8'h11);
        read_byte(1'b1, got);
        check("mr_byte1", got, 8'h22);
        check("mr_tx_ack#", 8'(tx_cnt - tx0), 8'd2);
        bus_stop();
        check("mr_busy", {7'd0, busy_o}, 8'h00);
        $display("txn multi-read: bytes 11,22 tx_ack pulses=%0d", tx_cnt - tx0);

        // ---------------- repeated START: write then read ----------------
        tx_data_i = 8'h77;
        rx0 = rx_cnt;
        bus_start();
        write_byte(8'h84, a);
        check("rs_aack0", {7'd0, a}, 8'h00);
        write_byte(8'h01, a);
        check("rs_dack",  {7'd0, a}, 8'h00);
        check("rs_rx",    rx_data_o, 8'h01);
        bus_start();
        check("rs_busy_sr", {7'd0, busy_o}, 8'h00);
        write_byte(8'h85, a);
        check("rs_aack1", {7'd0, a}, 8'h00);
        check("rs_busy_rd", {7'd0, busy_o}, 8'h01);
        read_byte(1'b1, got);
        check("rs_rdbyte", got, 8'h77);
        bus_stop();
        check("rs_rxv#", 8'(rx_cnt - rx0), 8'd1);
        $display("txn repeated-start: rx=%02h read=%02h", rx_data_o, got);

        // ---------------- abort: STOP after 4 data bits ----------------
        rx0 = rx_cnt;
        bus_start();
        write_byte(8'h84, a);
        check("ab_aack", {7'd0, a}, 8'h00);
        clock_bit(1'b1, b);
        clock_bit(1'b0, b);
        clock_bit(1'b1, b);
        clock_bit(1'b0, b);
        bus_stop();
        check("ab_rxv#", 8'(rx_cnt - rx0), 8'd0);
        check("ab_rx",   rx_data_o, 8'h01);
        check("ab_busy", {7'd0, busy_o}, 8'h00);
        $display("txn abort: partial byte dropped, rx=%02h", rx_data_o);

        // ---------------- reset while the target drives a read bit ----------------
        tx_data_i = 8'h00;
        bus_start();
        write_byte(8'h85, a);
        repeat (2) @(negedge clk_i);
        master_sda = 1'b1;
        wait_q(2);
        scl = 1'b1;
        wait_q(1);
        check("rr_oe_pre", {7'd0, sda_oe_o}, 8'h01);
        rst_n_i = 1'b0;
        #1;
        check("rr_oe_rst",   {7'd0, sda_oe_o}, 8'h00);
        check("rr_busy_rst", {7'd0, busy_o},   8'h00);
        check("rr_rx_rst",   rx_data_o,        8'h00);
        wait_q(1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        wait_q(2);
        $display("txn reset-mid-read: sda released, busy=%0b", busy_o);

        // The target must be back in IDLE and fully functional.
        rx0 = rx_cnt;
        bus_start();
        write_byte(8'h84, a);
        check("pr_aack", {7'd0, a}, 8'h00);
        write_byte(8'h3E, a);
        check("pr_dack", {7'd0, a}, 8'h00);
        bus_stop();
        check("pr_rx",   rx_data_o, 8'h3E);
        check("pr_rxv#", 8'(rx_cnt - rx0), 8'd1);
        $display("txn post-reset write: rx=%02h", rx_data_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
